ifac8_1_stage: RTL and testbench
================================

Name: ifac8_1_stage

Overview:
- Inverse-direction counterpart of the radix-2^3 stage-1 twiddle multiplier; used in the IFFT datapath.
- Applies the conjugate fac8_1 factor set to a 16-lane parallel complex vector, using fixed <2.8> coefficients.
- Generates its own factor-select sequence from a frame-synchronous beat counter, rather than taking sel from outside.
- Registered multiply, then rounding and saturation; 2-cycle valid pipeline between the IFFT butterfly stages.

Parameters:
- I_WIDTH, 13: signed input width per component.
- FAC_WIDTH, 22: signed product width (stage-1 register).
- O_WIDTH, 14: signed output width per component.
- DATA_WIDTH, 16: lanes per beat; must be even.
- SHIFT, 8: coefficient fraction bits; rounding constant is 2^(SHIFT-1).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_sof  in  1  first beat of a 4-beat frame; qualified by in_valid.
- din_re  in  I_WIDTH x DATA_WIDTH  signed real lanes.
- din_im  in  I_WIDTH x DATA_WIDTH  signed imaginary lanes.
- out_valid  out  1  output beat valid.
- out_sof  out  1  output frame start, aligned with out_valid.
- out_sel  out  2  factor index used for this output beat.
- dout_re  out  O_WIDTH x DATA_WIDTH  signed real lanes.
- dout_im  out  O_WIDTH x DATA_WIDTH  signed imaginary lanes.

Behaviour:
- Reset (async, rstn=0): all outputs are 0; beat counter = 0; all pipeline registers and valids = 0.
- Clock and reset: clk is the clock; rstn is asynchronous, active-low. Reset takes effect immediately and discards in-flight beats.
- Beat counter cnt[1:0] selects the factor for the current beat:
  - If in_valid && in_sof: the beat uses sel=0 and cnt <= 1.
  - Else if in_valid: the beat uses sel=cnt and cnt <= cnt+1, wrapping 3->0.
  - If !in_valid: cnt holds, so gaps between beats are allowed.
  - An in_sof in mid-frame restarts at sel=0; the partial frame is not flagged.
- Lower lanes (0..DATA_WIDTH/2-1): product is 256*din for both re and im, for every sel.
- Upper lanes, with a=din_re, b=din_im:
  - sel=0: re=256a, im=256b.
  - sel=1 (+j): re=-256b, im=256a.
  - sel=2: re=181a-181b, im=181a+181b.
  - sel=3: re=-181a-181b, im=181a-181b.
- Stage 1 (cycle 1): products are computed at FAC_WIDTH and registered together with valid, sof and sel.
- Stage 2 (cycle 2): y = (p + 128) >>> SHIFT, arithmetic shift (floor after bias), then saturated to the O_WIDTH signed range [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1].
  - Saturation is unreachable with default widths but is mandatory logic.
- Latency: exactly 2 clk from the accepted input beat to out_valid. Throughput is 1 beat/clk. There is no backpressure.
- Data and out_sel registers update only when the corresponding stage valid is 1; otherwise they hold their last value.
  - out_valid and out_sof are registered every cycle.
  - out_sof=1 only when out_valid=1.

Decomposition:
- Package fft_pkg holds:
  - typedef fac_sel_t (2-bit enum: FAC_ONE, FAC_NJ, FAC_W1, FAC_W3);
  - constant COEF_ONE=256;
  - constant COEF_R2=181;
  - function round_sat(p, SHIFT, O_WIDTH).
- Sub-module ifac8_1_lane: one upper-lane complex multiply plus rounding and saturation, instantiated DATA_WIDTH/2 times.
- Lower lanes are scaled inline.

Test Plan:
- Reset mid-stream: assert rstn=0 during beat 2 -> outputs and out_valid are 0 immediately; after release, the next in_sof beat gives out_sel=0.
- Frame of 4 beats, all lanes a=100, b=50, in_sof on beat 0 -> outputs 2 cycles later:
  - lower lanes (100,50) on every beat;
  - upper lanes (100,50), (-50,100), (35,106), (-106,35) for sel 0..3;
  - out_sof on the first output beat only.
- Rounding negatives: upper lanes a=-1, b=0, sel=2 -> (-1,-1); a=1, b=0, sel=2 -> (1,1).
- Gapped input: in_valid pattern 1,0,0,1,1,0,1 with a single in_sof -> out_sel 0,1,2,3 on valid outputs only; cnt holds through gaps.
- Mid-frame in_sof on beat 2 -> that beat uses sel=0; the following beats use 1,2,3; 5th consecutive beat wraps to sel=0.
- Extremes: a=-4096, b=-4096 -> sel=1 upper lane (4096,-4096); sel=3 upper lane re=5792, im=0. No saturation occurs at default widths.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types, coefficients and the rounding/saturation helper for the FFT/IFFT twiddle stages.
package fft_pkg;

    typedef enum logic [1:0] {
        FAC_ONE = 2'd0,
        FAC_NJ  = 2'd1,
        FAC_W1  = 2'd2,
        FAC_W3  = 2'd3
    } fac_sel_t;

    // <2.8> fixed-point coefficients: 1.0 and sqrt(2)/2
    localparam int COEF_ONE = 256;
    localparam int COEF_R2  = 181;

    // Round half up by biasing then flooring, then clamp to an o_width signed range.
    function automatic logic signed [31:0] round_sat(
        input logic signed [31:0] p,
        input int unsigned        shift,
        input int unsigned        o_width
    );
        logic signed [31:0] y;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        y  = (p + (32'sd1 <<< (shift - 1))) >>> shift;
        hi = (32'sd1 <<< (o_width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (o_width - 1));
        if (y > hi) begin
            return hi;
        end else if (y < lo) begin
            return lo;
        end
        return y;
    endfunction

endpackage

// File: rtl/ifac8_1_lane.sv
// One upper-lane conjugate fac8_1 complex multiply, registered, then rounded and saturated.
module ifac8_1_lane
    import fft_pkg::*;
#(
    parameter int unsigned I_WIDTH   = 13,
    parameter int unsigned FAC_WIDTH = 22,
    parameter int unsigned O_WIDTH   = 14,
    parameter int unsigned SHIFT     = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en1,
    input  logic                        en2,
    input  fac_sel_t                    sel,
    input  logic signed [I_WIDTH-1:0]   a,
    input  logic signed [I_WIDTH-1:0]   b,
    output logic        [O_WIDTH-1:0]   y_re,
    output logic        [O_WIDTH-1:0]   y_im
);

    localparam logic signed [FAC_WIDTH-1:0] K_ONE = FAC_WIDTH'(COEF_ONE);
    localparam logic signed [FAC_WIDTH-1:0] K_R2  = FAC_WIDTH'(COEF_R2);

    logic signed [FAC_WIDTH-1:0] ax;
    logic signed [FAC_WIDTH-1:0] bx;
    logic signed [FAC_WIDTH-1:0] sum;
    logic signed [FAC_WIDTH-1:0] dif;
    logic signed [FAC_WIDTH-1:0] pr_c;
    logic signed [FAC_WIDTH-1:0] pi_c;
    logic signed [FAC_WIDTH-1:0] p_re;
    logic signed [FAC_WIDTH-1:0] p_im;

    // Factor products; sqrt(2)/2 terms share one multiply over (a-b) or (a+b)
    always_comb begin
        ax   = FAC_WIDTH'(a);
        bx   = FAC_WIDTH'(b);
        sum  = ax + bx;
        dif  = ax - bx;
        pr_c = '0;
        pi_c = '0;
        case (sel)
            FAC_ONE: begin pr_c = K_ONE * ax;    pi_c = K_ONE * bx;  end
            FAC_NJ:  begin pr_c = -(K_ONE * bx); pi_c = K_ONE * ax;  end
            FAC_W1:  begin pr_c = K_R2 * dif;    pi_c = K_R2 * sum;  end
            FAC_W3:  begin pr_c = -(K_R2 * sum); pi_c = K_R2 * dif;  end
            default: begin pr_c = '0;            pi_c = '0;          end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_re <= '0;
            p_im <= '0;
        end else if (en1) begin
            p_re <= pr_c;
            p_im <= pi_c;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_re <= '0;
            y_im <= '0;
        end else if (en2) begin
            y_re <= O_WIDTH'(round_sat(32'(p_re), SHIFT, O_WIDTH));
            y_im <= O_WIDTH'(round_sat(32'(p_im), SHIFT, O_WIDTH));
        end
    end

endmodule

// File: rtl/ifac8_1_stage.sv
// IFFT radix-2^3 stage-1 conjugate twiddle: self-sequenced factor select, 2-cycle multiply/round pipeline.
module ifac8_1_stage
    import fft_pkg::*;
#(
    parameter int unsigned I_WIDTH    = 13,
    parameter int unsigned FAC_WIDTH  = 22,
    parameter int unsigned O_WIDTH    = 14,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SHIFT      = 8
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   in_valid,
    input  logic                                   in_sof,
    input  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]     din_re,
    input  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]     din_im,
    output logic                                   out_valid,
    output logic                                   out_sof,
    output logic [1:0]                             out_sel,
    output logic [DATA_WIDTH-1:0][O_WIDTH-1:0]     dout_re,
    output logic [DATA_WIDTH-1:0][O_WIDTH-1:0]     dout_im
);

    localparam int unsigned HALF = DATA_WIDTH / 2;
    localparam logic signed [FAC_WIDTH-1:0] K_ONE = FAC_WIDTH'(COEF_ONE);

    logic [1:0]                  cnt;
    fac_sel_t                    sel_c;
    logic                        v1;
    logic                        sof1;
    fac_sel_t                    sel1;
    logic signed [FAC_WIDTH-1:0] lo_p_re [HALF];
    logic signed [FAC_WIDTH-1:0] lo_p_im [HALF];
    logic [O_WIDTH-1:0]          lo_re   [HALF];
    logic [O_WIDTH-1:0]          lo_im   [HALF];

    // A start-of-frame beat always takes factor 0, even in mid-frame
    assign sel_c = in_sof ? FAC_ONE : fac_sel_t'(cnt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 2'd0;
        end else if (in_valid) begin
            cnt <= in_sof ? 2'd1 : cnt + 2'd1;
        end
    end

    // Stage 1 control and lower-lane products
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1   <= 1'b0;
            sof1 <= 1'b0;
            sel1 <= FAC_ONE;
            for (int i = 0; i < int'(HALF); i++) begin
                lo_p_re[i] <= '0;
                lo_p_im[i] <= '0;
            end
        end else begin
            v1   <= in_valid;
            sof1 <= in_valid & in_sof;
            if (in_valid) begin
                sel1 <= sel_c;
                for (int i = 0; i < int'(HALF); i++) begin
                    lo_p_re[i] <= K_ONE * FAC_WIDTH'($signed(din_re[i]));
                    lo_p_im[i] <= K_ONE * FAC_WIDTH'($signed(din_im[i]));
                end
            end
        end
    end

    // Stage 2 control and lower-lane rounding
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_sel   <= 2'd0;
            for (int i = 0; i < int'(HALF); i++) begin
                lo_re[i] <= '0;
                lo_im[i] <= '0;
            end
        end else begin
            out_valid <= v1;
            out_sof   <= v1 & sof1;
            if (v1) begin
                out_sel <= sel1;
                for (int i = 0; i < int'(HALF); i++) begin
                    lo_re[i] <= O_WIDTH'(round_sat(32'(lo_p_re[i]), SHIFT, O_WIDTH));
                    lo_im[i] <= O_WIDTH'(round_sat(32'(lo_p_im[i]), SHIFT, O_WIDTH));
                end
            end
        end
    end

    for (genvar g = 0; g < HALF; g++) begin : g_lane
        assign dout_re[g] = lo_re[g];
        assign dout_im[g] = lo_im[g];

        ifac8_1_lane #(
            .I_WIDTH   (I_WIDTH),
            .FAC_WIDTH (FAC_WIDTH),
            .O_WIDTH   (O_WIDTH),
            .SHIFT     (SHIFT)
        ) u_lane (
            .clk  (clk),
            .rstn (rstn),
            .en1  (in_valid),
            .en2  (v1),
            .sel  (sel_c),
            .a    (din_re[HALF+g]),
            .b    (din_im[HALF+g]),
            .y_re (dout_re[HALF+g]),
            .y_im (dout_im[HALF+g])
        );
    end

endmodule

// File: tb/tb_ifac8_1_stage.sv
// Scoreboard bench for ifac8_1_stage: expected beats queued at drive time, compared when out_valid rises.
module tb_ifac8_1_stage;

    localparam int IW = 13;
    localparam int OW = 14;
    localparam int DW = 16;

    typedef logic [DW-1:0][IW-1:0] din_t;
    typedef logic [DW-1:0][OW-1:0] dout_t;
    typedef struct {
        logic [1:0] sel;
        logic       sof;
        dout_t      re;
        dout_t      im;
        int         cyc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rstn;
    logic  in_valid;
    logic  in_sof;
    din_t  din_re;
    din_t  din_im;
    logic  out_valid;
    logic  out_sof;
    logic [1:0] out_sel;
    dout_t dout_re;
    dout_t dout_im;

    din_t  cur_re;
    din_t  cur_im;
    exp_t  q[$];
    int    mcnt   = 0;
    int    cyc    = 0;
    int    n_vec  = 0;
    int    n_err  = 0;

    ifac8_1_stage dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .din_re    (din_re),
        .din_im    (din_im),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_sel   (out_sel),
        .dout_re   (dout_re),
        .dout_im   (dout_im)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bias by half an LSB, then floor-divide by 256 and clamp to 14-bit signed
    function automatic int rnd(input int p);
        int t;
        int qq;
        t  = p + 128;
        qq = t / 256;
        if (t < 0 && (t % 256) != 0) qq = qq - 1;
        if (qq > 8191) qq = 8191;
        if (qq < -8192) qq = -8192;
        return qq;
    endfunction

    function automatic exp_t model(input int sel, input bit sof, input din_t re, input din_t im);
        exp_t e;
        int a, b, pr, pi;
        e.sel = 2'(sel);
        e.sof = sof;
        e.cyc = 0;
        for (int l = 0; l < DW; l++) begin
            a = int'($signed(re[l]));
            b = int'($signed(im[l]));
            if (l < DW / 2) begin
                pr = 256 * a; pi = 256 * b;
            end else begin
                case (sel)
                    0:       begin pr = 256 * a;           pi = 256 * b;           end
                    1:       begin pr = -256 * b;          pi = 256 * a;           end
                    2:       begin pr = 181 * a - 181 * b; pi = 181 * a + 181 * b; end
                    default: begin pr = -181 * a - 181 * b; pi = 181 * a - 181 * b; end
                endcase
            end
            e.re[l] = OW'(rnd(pr));
            e.im[l] = OW'(rnd(pi));
        end
        return e;
    endfunction

    task automatic fill(input int a, input int b);
        for (int l = 0; l < DW; l++) begin
            cur_re[l] = IW'(a);
            cur_im[l] = IW'(b);
        end
    endtask

    task automatic drive(input bit v, input bit s);
        exp_t e;
        int   sel;
        @(posedge clk);
        #1;
        in_valid = v;
        in_sof   = s;
        din_re   = cur_re;
        din_im   = cur_im;
        if (v) begin
            sel  = s ? 0 : mcnt;
            mcnt = s ? 1 : (mcnt + 1) % 4;
            e = model(sel, s, cur_re, cur_im);
            e.cyc = cyc + 2;
            q.push_back(e);
        end
    endtask

    task automatic check_reset_state();
        check("rst_valid", 256'(out_valid), 256'(0));
        check("rst_sof",   256'(out_sof),   256'(0));
        check("rst_sel",   256'(out_sel),   256'(0));
        check("rst_re",    256'(dout_re),   256'(0));
        check("rst_im",    256'(dout_im),   256'(0));
    endtask

    exp_t m;
    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 256'(1), 256'(0));
                end else begin
                    m = q.pop_front();
                    check("latency", 256'(cyc),     256'(m.cyc));
                    check("out_sel", 256'(out_sel), 256'(m.sel));
                    check("out_sof", 256'(out_sof), 256'(m.sof));
                    check("dout_re", 256'(dout_re), 256'(m.re));
                    check("dout_im", 256'(dout_im), 256'(m.im));
                end
            end else begin
                check("sof_idle", 256'(out_sof), 256'(0));
            end
        end
    end

    initial begin
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        fill(0, 0);
        din_re   = cur_re;
        din_im   = cur_im;
        #1;
        check_reset_state();
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

        // Reset asserted while beat 2 is on the inputs discards everything in flight
        fill(7, 3);
        drive(1, 1); drive(1, 0); drive(1, 0);
        #1;
        rstn = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        q.delete();
        mcnt = 0;
        #1;
        check_reset_state();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;

        // Nominal frame a=100, b=50
        fill(100, 50);
        drive(1, 1); drive(1, 0); drive(1, 0); drive(1, 0);
        drive(0, 0);

        // Rounding of small negatives and positives
        fill(0, 0);  drive(1, 1); drive(1, 0);
        fill(-1, 0); drive(1, 0);
        fill(1, 0);  drive(1, 0);
        fill(0, 0);  drive(1, 1); drive(1, 0);
        fill(1, 0);  drive(1, 0);
        drive(0, 0);

        // Gapped input with a single start-of-frame
        fill(20, -30);
        drive(1, 1); drive(0, 0); drive(0, 0); drive(1, 0);
        drive(1, 0); drive(0, 0); drive(1, 0);
        drive(0, 0);

        // Mid-frame restart, then wrap on the fifth consecutive beat
        fill(-77, 41);
        drive(1, 1); drive(1, 0); drive(1, 1); drive(1, 0);
        drive(1, 0); drive(1, 0); drive(1, 0);
        drive(0, 0);

        // Most negative inputs
        fill(-4096, -4096);
        drive(1, 1); drive(1, 0); drive(1, 0); drive(1, 0);
        drive(0, 0);

        // Random lanes, random valid gaps and frame starts
        for (int k = 0; k < 300; k++) begin
            for (int l = 0; l < DW; l++) begin
                cur_re[l] = IW'($urandom);
                cur_im[l] = IW'($urandom);
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        end

        repeat (5) drive(0, 0);
        check("queue_empty", 256'(q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
